// File: rtl/aemb2_bus_pkg.sv
// aemb2_bus_pkg: shared state encoding, error data word and width helper for aeMB2 bus bridges
package aemb2_bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DAT = 32'hDEAD_BEEF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/aemb2_wb_timeout.sv
// aemb2_wb_timeout: saturating wait counter with a registered expiry flag at count TO-1
module aemb2_wb_timeout
    import aemb2_bus_pkg::*;
#(
    parameter int TO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    localparam int CW = clog2(TO + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt;

    // saturates instead of wrapping so a stuck access cannot re-arm the flag
    always_comb nxt = clr_i ? '0 : (run_i && !(&cnt)) ? cnt + 1'b1 : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            expire_o <= 1'b0;
        end else begin
            cnt      <= nxt;
            expire_o <= nxt == CW'(TO - 1);
        end
    end

endmodule

// File: rtl/aemb2_dwb_decoder.sv
// aemb2_dwb_decoder: DWB to NS-slave Wishbone bridge with index decode, timeout and error response
module aemb2_dwb_decoder
    import aemb2_bus_pkg::*;
#(
    parameter int AW  = 32,
    parameter int NS  = 4,
    parameter int DSB = 28,
    parameter int SW  = 2,
    parameter int TO  = 255
) (
    input  logic               sys_clk_i,
    input  logic               sys_rst_i,
    input  logic [AW-1:2]      dwb_adr_o,
    input  logic [31:0]        dwb_dat_o,
    input  logic [3:0]         dwb_sel_o,
    input  logic               dwb_stb_o,
    input  logic               dwb_wre_o,
    input  logic               dwb_cyc_o,
    input  logic               dwb_tag_o,
    output logic [31:0]        dwb_dat_i,
    output logic               dwb_ack_i,
    output logic [NS-1:0]      swb_stb_o,
    output logic [AW-1:2]      swb_adr_o,
    output logic [31:0]        swb_dat_o,
    output logic [3:0]         swb_sel_o,
    output logic               swb_wre_o,
    output logic               swb_cyc_o,
    output logic               swb_tag_o,
    input  logic [32*NS-1:0]   swb_dat_i,
    input  logic [NS-1:0]      swb_ack_i,
    input  logic               err_clr_i,
    output logic               bus_err_o,
    output logic [AW-1:2]      err_adr_o
);

    state_t        state;
    logic [SW-1:0] idx;
    logic [SW-1:0] sel_idx;
    logic          mapped;
    logic          req;
    logic          hit;
    logic          expire;

    assign idx    = dwb_adr_o[DSB+SW-1:DSB];
    assign mapped = int'(idx) < NS;
    // a request still held while its ack is on the bus is the one just answered
    assign req    = dwb_stb_o & dwb_cyc_o & ~dwb_ack_i;
    assign hit    = swb_ack_i[sel_idx];

    aemb2_wb_timeout #(.TO(TO)) u_timeout (
        .clk      (sys_clk_i),
        .rst      (sys_rst_i),
        .clr_i    (state == S_IDLE && req && mapped),
        .run_i    (state == S_WAIT),
        .expire_o (expire)
    );

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state     <= S_IDLE;
            sel_idx   <= '0;
            dwb_dat_i <= '0;
            dwb_ack_i <= 1'b0;
            swb_stb_o <= '0;
            swb_adr_o <= '0;
            swb_dat_o <= '0;
            swb_sel_o <= '0;
            swb_wre_o <= 1'b0;
            swb_cyc_o <= 1'b0;
            swb_tag_o <= 1'b0;
            bus_err_o <= 1'b0;
            err_adr_o <= '0;
        end else begin
            dwb_ack_i <= 1'b0;
            bus_err_o <= bus_err_o & ~err_clr_i;
            case (state)
                S_IDLE: if (req) begin
                    swb_adr_o <= dwb_adr_o;
                    swb_dat_o <= dwb_dat_o;
                    swb_sel_o <= dwb_sel_o;
                    swb_wre_o <= dwb_wre_o;
                    swb_tag_o <= dwb_tag_o;
                    sel_idx   <= idx;
                    swb_stb_o <= mapped ? NS'(1) << idx : '0;
                    swb_cyc_o <= mapped;
                    state     <= mapped ? S_WAIT : S_ERR;
                end
                S_WAIT: if (!dwb_cyc_o || hit || expire) begin
                    swb_stb_o <= '0;
                    swb_cyc_o <= 1'b0;
                    dwb_ack_i <= dwb_cyc_o && hit;
                    dwb_dat_i <= (dwb_cyc_o && hit) ? swb_dat_i[{sel_idx, 5'd0} +: 32] : dwb_dat_i;
                    state     <= !dwb_cyc_o ? S_IDLE : hit ? S_ACK : S_ERR;
                end
                S_ACK: state <= S_IDLE;
                S_ERR: begin
                    dwb_ack_i <= 1'b1;
                    dwb_dat_i <= ERR_DAT;
                    bus_err_o <= 1'b1;
                    err_adr_o <= swb_adr_o;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
